// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the prefetching instruction-fetch stage: hazard
// control encoding, instruction size and default geometry, mirroring the
// codebase-wide definitions consumed by if_id_reg and hazard_unit.
package if_fetch_queue_pkg;

  localparam int ISA_WIDTH_DEF     = 32;
  localparam int ROM_DEPTH_DEF     = 14;
  localparam int INSTRUCTION_BYTES = 4;
  localparam int HAZD_CTL_WIDTH    = 2;

  typedef enum logic [HAZD_CTL_WIDTH-1:0] {
    HAZD_CTL_NORMAL = 2'b00,
    HAZD_CTL_NO_OP  = 2'b01,
    HAZD_CTL_RETRY  = 2'b10
  } hazd_ctl_e;

endpackage

// File: rtl/if_fetch_queue_fetch_ram.sv
// Single-port synchronous instruction RAM, read-first. The parent muxes the
// fetch path and the UART loader onto this one port.
module fetch_ram #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Registered read of the old contents; a write on the same cycle updates the array.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Decoupled instruction prefetcher: owns the fetch PC, issues one RAM read at
// a time when the queue has room, and presents PC-tagged instructions to the
// decode stage. Redirects, pc_reset and UART loading flush everything.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int                 ISA_WIDTH = ISA_WIDTH_DEF,
  parameter int                 ROM_DEPTH = ROM_DEPTH_DEF,
  parameter int                 FQ_DEPTH  = 4,
  parameter logic [ISA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_disable_i,
  input  logic                          uart_write_enable_i,
  input  logic [ROM_DEPTH:0]            uart_addr_i,
  input  logic [ISA_WIDTH-1:0]          uart_data_i,
  input  logic                          redirect_valid_i,
  input  logic [ISA_WIDTH-1:0]          redirect_pc_i,
  input  logic                          pc_reset_i,
  input  logic [HAZD_CTL_WIDTH-1:0]     hazard_control_i,
  output logic                          inst_valid_o,
  output logic [ISA_WIDTH-1:0]          inst_o,
  output logic [ISA_WIDTH-1:0]          inst_pc_o,
  output logic [ISA_WIDTH-1:0]          fetch_pc_o,
  output logic [$clog2(FQ_DEPTH):0]     fq_count_o,
  output logic                          fq_full_o,
  output logic                          fq_empty_o
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Architectural state
  logic [ISA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ISA_WIDTH-1:0] issued_pc_q;
  logic                 inflight_q, inflight_d;
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ISA_WIDTH-1:0] fq_inst_q [FQ_DEPTH];
  logic [ISA_WIDTH-1:0] fq_pc_q   [FQ_DEPTH];

  // Control
  logic                 flush;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 empty;
  logic [CNT_W:0]       occupancy;
  logic [ISA_WIDTH-1:0] redirect_aligned;

  // RAM port
  logic                 ram_en;
  logic                 ram_we;
  logic [ROM_DEPTH-1:0] ram_addr;
  logic [ISA_WIDTH-1:0] ram_rdata;

  assign empty            = (count_q == '0);
  assign occupancy        = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign redirect_aligned = redirect_pc_i & ~ISA_WIDTH'(INSTRUCTION_BYTES - 1);

  // Issue/push/pop decisions and next-state for PC, pointers and count
  always_comb begin
    flush      = pc_reset_i | redirect_valid_i | ~uart_disable_i;
    // Credit counts the in-flight read; a same-cycle pop is deliberately not credited.
    issue      = uart_disable_i & ~pc_reset_i & ~redirect_valid_i
               & (occupancy < (CNT_W+1)'(FQ_DEPTH));
    push       = inflight_q & ~flush;
    pop        = inst_valid_o & (hazard_control_i == HAZD_CTL_NORMAL) & ~flush;

    fetch_pc_d = fetch_pc_q;
    inflight_d = issue;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (pc_reset_i) begin
      fetch_pc_d = RESET_PC;
    end else if (redirect_valid_i) begin
      fetch_pc_d = redirect_aligned;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ISA_WIDTH'(INSTRUCTION_BYTES);
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control-state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      inflight_q  <= inflight_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      if (issue) issued_pc_q <= fetch_pc_q;
    end
  end

  // Queue entries: each slot captures RAM data and issued PC when the tail points at it
  for (genvar gi = 0; gi < FQ_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fq_inst_q[gi] <= '0;
        fq_pc_q[gi]   <= '0;
      end else if (push && tail_q == PTR_W'(gi)) begin
        fq_inst_q[gi] <= ram_rdata;
        fq_pc_q[gi]   <= issued_pc_q;
      end
    end
  end

  // Single RAM port shared by fetch (normal mode) and the UART loader
  always_comb begin
    ram_we   = ~uart_disable_i & uart_write_enable_i & ~uart_addr_i[ROM_DEPTH];
    ram_en   = issue | ram_we;
    ram_addr = uart_disable_i ? fetch_pc_q[ROM_DEPTH+1:2] : uart_addr_i[ROM_DEPTH-1:0];
  end

  fetch_ram #(
    .ADDR_W (ROM_DEPTH),
    .DATA_W (ISA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (uart_data_i),
    .rdata_o (ram_rdata)
  );

  assign inst_valid_o = ~empty & (hazard_control_i != HAZD_CTL_NO_OP);
  assign inst_o       = fq_inst_q[head_q];
  assign inst_pc_o    = fq_pc_q[head_q];
  assign fetch_pc_o   = fetch_pc_q;
  assign fq_count_o   = count_q;
  assign fq_empty_o   = empty;
  assign fq_full_o    = (count_q == CNT_W'(FQ_DEPTH));

endmodule
